tinker_mem_arbiter: RTL

//  Shares the single Von Neumann memory port between instruction fetch and data load/store requesters.
//  - Sits between the fetch/control path and the memory block.
//  - Provides a valid/grant/response handshake per requester.
//  - Sequences each access over MEM_LAT cycles and returns the read data or a write acknowledge.

---
 rtl/tinker_mem_arbiter_if.sv | 36 +++
 rtl/tinker_mem_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/tinker_mem_arbiter_if.sv
// Requester and memory-side bus of tinker_mem_arbiter.
// The arbiter connects through the slave modport; the requester/memory side uses the master modport.
interface tinker_mem_arbiter_if;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [63:0] d_rdata;
  logic [63:0] mem_addr;
  logic        mem_read_instr;
  logic        mem_read_data;
  logic        mem_write;
  logic [63:0] mem_write_data;
  logic [31:0] mem_instr_in;
  logic [63:0] mem_data_in;
  logic        busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_instr_in, mem_data_in,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_read_instr, mem_read_data, mem_write, mem_write_data, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_instr_in, mem_data_in,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_read_instr, mem_read_data, mem_write, mem_write_data, busy
  );
endinterface

// File: rtl/tinker_mem_arbiter.sv
// Shares one memory port between instruction fetch and data load/store.
// Define TINKER_ARB_RR_EN for round-robin arbitration instead of data priority with a fetch starvation guard.
module tinker_mem_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  tinker_mem_arbiter_if.slave   bus
);
  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             own_d;
  logic             is_store;
  logic             if_win, d_win;
  logic             if_gnt, d_gnt;

`ifdef TINKER_ARB_RR_EN
  logic last_d;

  // On conflict the requester that did not get the previous grant wins.
  always_comb begin
    if_win = bus.if_req && (!bus.d_req || last_d);
    d_win  = bus.d_req && !(bus.if_req && last_d);
  end

  always_ff @(posedge clk) begin
    if (reset)
      last_d <= 1'b0;
    else if (if_gnt || d_gnt)
      last_d <= d_gnt;
  end
`else
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  logic [SW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt == STARVE_TOP);

  always_comb begin
    if_win = bus.if_req && (!bus.d_req || starved);
    d_win  = bus.d_req && !(bus.if_req && starved);
  end

  // Counts data grants taken while fetch waits; saturates so fetch keeps winning.
  always_ff @(posedge clk) begin
    if (reset || if_gnt || !bus.if_req)
      starve_cnt <= '0;
    else if (d_gnt && !starved)
      starve_cnt <= starve_cnt + 1'b1;
  end
`endif

  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    case (state)
      IDLE: begin
        if (!reset) begin
          if_gnt = if_win;
          d_gnt  = d_win;
          if (if_win || d_win) state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  assign bus.if_gnt = if_gnt;
  assign bus.d_gnt  = d_gnt;
  assign bus.busy   = (state == BUSY);

  // Grant edge: latch the access; BUSY: hold it, then capture the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt                <= '0;
      own_d              <= 1'b0;
      is_store           <= 1'b0;
      bus.mem_addr       <= '0;
      bus.mem_write_data <= '0;
      bus.mem_read_instr <= 1'b0;
      bus.mem_read_data  <= 1'b0;
      bus.mem_write      <= 1'b0;
      bus.if_rdata       <= '0;
      bus.d_rdata        <= '0;
      bus.if_rvalid      <= 1'b0;
      bus.d_rvalid       <= 1'b0;
    end else begin
      bus.if_rvalid <= 1'b0;
      bus.d_rvalid  <= 1'b0;
      if (if_gnt || d_gnt) begin
        cnt                <= CNT_LAST;
        own_d              <= d_gnt;
        is_store           <= d_gnt && bus.d_we;
        bus.mem_addr       <= d_gnt ? bus.d_addr : bus.if_addr;
        bus.mem_read_instr <= if_gnt;
        bus.mem_read_data  <= d_gnt && !bus.d_we;
        bus.mem_write      <= d_gnt && bus.d_we;
        if (d_gnt && bus.d_we) bus.mem_write_data <= bus.d_wdata;
      end else if (state == BUSY) begin
        bus.mem_write <= 1'b0;
        if (cnt == '0) begin
          bus.mem_read_instr <= 1'b0;
          bus.mem_read_data  <= 1'b0;
          if (own_d) begin
            bus.d_rdata  <= is_store ? '0 : bus.mem_data_in;
            bus.d_rvalid <= 1'b1;
          end else begin
            bus.if_rdata  <= bus.mem_instr_in;
            bus.if_rvalid <= 1'b1;
          end
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end
endmodule
